// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone controller: FSM state codes and
// default sizing.
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ENTRY    = 2'd2,
    ALARM    = 2'd3
  } state_e;

  localparam int NZ_DEF    = 8;
  localparam int DELAY_DEF = 16;

endpackage

// File: rtl/alarm_priority_enc.sv
// Lowest-index-wins priority encoder over the latched zone register.
// Outputs the index of the first set bit and an any-set flag.
module alarm_priority_enc #(
  parameter  int NZ = 8,
  localparam int ZW = $clog2(NZ)
) (
  input  logic [NZ-1:0] pending,
  output logic [ZW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    for (int i = NZ - 1; i >= 0; i--) begin
      if (pending[i]) idx = ZW'(i);
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/alarm_zone_controller.sv
// Zone alarm FSM: arms on request, latches tripped zones, runs an entry
// delay, then sounds the buzzer until every latched zone is acknowledged.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter  int NZ    = NZ_DEF,
  parameter  int DELAY = DELAY_DEF,
  localparam int ZW    = $clog2(NZ)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          disarm,
  input  logic [NZ-1:0] zone,
  input  logic          ack,
  output logic [ZW-1:0] intruder_zone,
  output logic          valid,
  output logic          buzzer,
  output logic [NZ-1:0] pending,
  output logic [1:0]    state
);

  localparam int            CW       = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  state_e        st_q;
  logic [CW-1:0] cnt_q;
  logic [NZ-1:0] ack_clr;
  logic [NZ-1:0] pend_nxt;

  alarm_priority_enc #(.NZ(NZ)) u_enc (
    .pending (pending),
    .idx     (intruder_zone),
    .valid   (valid)
  );

  // Set beats clear: a zone still asserted keeps its bit even when acked.
  always_comb begin
    ack_clr = '0;
    if (st_q == ALARM && ack && valid) ack_clr[intruder_zone] = 1'b1;
    pend_nxt = (pending & ~ack_clr) | zone;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= DISARMED;
      pending <= '0;
      cnt_q   <= '0;
    end else if (disarm) begin
      st_q    <= DISARMED;
      pending <= '0;
      cnt_q   <= '0;
    end else begin
      case (st_q)
        DISARMED: begin
          pending <= '0;
          cnt_q   <= '0;
          if (arm) st_q <= ARMED;
        end
        ARMED: begin
          pending <= pend_nxt;
          cnt_q   <= '0;
          if (|zone) st_q <= ENTRY;
        end
        ENTRY: begin
          pending <= pend_nxt;
          if (cnt_q == CNT_LAST) begin
            st_q  <= ALARM;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ALARM: begin
          pending <= pend_nxt;
          cnt_q   <= '0;
          // Only an ack that empties the register re-arms; a fresh trip stays in ALARM.
          if (ack_clr != '0 && pend_nxt == '0) st_q <= ARMED;
        end
        default: begin
          st_q    <= DISARMED;
          pending <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state  = st_q;
  assign buzzer = (st_q == ALARM);

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Scoreboard bench for alarm_zone_controller (NZ=8, DELAY=4): stimulus queues
// hand-computed expectations tagged by clock edge, monitors pop and compare.
module tb_alarm_zone_controller;

  localparam int NZ = 8;
  localparam int DELAY = 4;
  localparam logic [1:0] S_DIS = 2'd0, S_ARM = 2'd1, S_ENT = 2'd2, S_ALM = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0, disarm = 1'b0, ack = 1'b0;
  logic [NZ-1:0] zone = '0;
  logic [2:0]    intruder_zone;
  logic          valid, buzzer;
  logic [NZ-1:0] pending;
  logic [1:0]    state;

  alarm_zone_controller #(.NZ(NZ), .DELAY(DELAY)) dut (
    .clk           (clk),
    .reset         (reset),
    .arm           (arm),
    .disarm        (disarm),
    .zone          (zone),
    .ack           (ack),
    .intruder_zone (intruder_zone),
    .valid         (valid),
    .buzzer        (buzzer),
    .pending       (pending),
    .state         (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;   // edge after which to check; -1 = immediately after reset rises
    string      nm;
    logic [1:0] st;
    logic [7:0] p;
    logic [2:0] iz;
    logic       v;
    logic       b;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic compare(input exp_t e);
    checks++;
    if ({state, pending, intruder_zone, valid, buzzer} !== {e.st, e.p, e.iz, e.v, e.b}) begin
      errors++;
      $display("FAIL %s: got st=%0d pend=%h iz=%0d valid=%b buz=%b, want st=%0d pend=%h iz=%0d valid=%b buz=%b",
               e.nm, state, pending, intruder_zone, valid, buzzer, e.st, e.p, e.iz, e.v, e.b);
    end
  endtask

  // Monitors: clocked checks on the falling edge, async-reset checks just after reset rises.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc <= cyc) compare(q.pop_front());
  end

  always @(posedge reset) begin
    #1;
    while (q.size() > 0 && q[0].cyc < 0) compare(q.pop_front());
  end

  task automatic drive(input logic a, input logic d, input logic [7:0] z, input logic k);
    arm = a; disarm = d; zone = z; ack = k;
  endtask

  task automatic exp_at(input int c, input string nm, input logic [1:0] st, input logic [7:0] p,
                        input logic [2:0] iz, input logic v, input logic b);
    exp_t e;
    e.cyc = c; e.nm = nm; e.st = st; e.p = p; e.iz = iz; e.v = v; e.b = b;
    q.push_back(e);
  endtask

  task automatic exp_next(input string nm, input logic [1:0] st, input logic [7:0] p,
                          input logic [2:0] iz, input logic v, input logic b);
    exp_at(cyc + 1, nm, st, p, iz, v, b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    exp_next("rst_hold", S_DIS, 8'h00, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Test 1: arm, one-cycle trip on zone 5, buzzer after exactly DELAY cycles
    drive(1, 0, 8'h00, 0); exp_next("t1_arm", S_ARM, 8'h00, 0, 0, 0); tick();
    drive(0, 0, 8'h20, 0); exp_next("t1_latch", S_ENT, 8'h20, 5, 1, 0); tick();
    drive(0, 0, 8'h00, 0);
    for (int i = 1; i < DELAY; i++) begin
      exp_next($sformatf("t1_entry%0d", i), S_ENT, 8'h20, 5, 1, 0); tick();
    end
    exp_next("t1_alarm", S_ALM, 8'h20, 5, 1, 1); tick();

    // Test 2: add zone 2 in ALARM, ack twice back to ARMED
    drive(0, 0, 8'h04, 0); exp_next("t2_add", S_ALM, 8'h24, 2, 1, 1); tick();
    drive(0, 0, 8'h00, 1); exp_next("t2_ack1", S_ALM, 8'h20, 5, 1, 1); tick();
    drive(0, 0, 8'h00, 1); exp_next("t2_ack2", S_ARM, 8'h00, 0, 0, 0); tick();
    drive(1, 0, 8'h00, 1); exp_next("armed_ack_arm_ign", S_ARM, 8'h00, 0, 0, 0); tick();

    // Test 4: ack colliding with re-trip of the same zone keeps it latched
    drive(0, 0, 8'h01, 0); exp_next("t4_latch", S_ENT, 8'h01, 0, 1, 0); tick();
    drive(0, 0, 8'h00, 0);
    for (int i = 1; i < DELAY; i++) begin
      exp_next($sformatf("t4_entry%0d", i), S_ENT, 8'h01, 0, 1, 0); tick();
    end
    exp_next("t4_alarm", S_ALM, 8'h01, 0, 1, 1); tick();
    drive(0, 0, 8'h01, 1); exp_next("t4_set_wins", S_ALM, 8'h01, 0, 1, 1); tick();
    drive(0, 0, 8'h00, 1); exp_next("t4_ack_clear", S_ARM, 8'h00, 0, 0, 0); tick();

    // Test 3: disarm at counter=2 in ENTRY, buzzer must never rise
    drive(0, 0, 8'h80, 0); exp_next("t3_latch", S_ENT, 8'h80, 7, 1, 0); tick();
    drive(0, 0, 8'h00, 1); exp_next("t3_entry_ack_ign", S_ENT, 8'h80, 7, 1, 0); tick();
    drive(0, 0, 8'h00, 0); exp_next("t3_entry2", S_ENT, 8'h80, 7, 1, 0); tick();
    drive(0, 1, 8'h00, 0); exp_next("t3_disarm", S_DIS, 8'h00, 0, 0, 0); tick();
    drive(0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      exp_next($sformatf("t3_quiet%0d", i), S_DIS, 8'h00, 0, 0, 0); tick();
    end

    // Test 5: disarm beats arm; zones ignored while disarmed
    drive(1, 1, 8'h00, 0); exp_next("t5_arm_disarm", S_DIS, 8'h00, 0, 0, 0); tick();
    drive(0, 0, 8'hFF, 0); exp_next("t5_zone_ign0", S_DIS, 8'h00, 0, 0, 0); tick();
    exp_next("t5_zone_ign1", S_DIS, 8'h00, 0, 0, 0); tick();

    // Test 6: async reset pulse between edges while in ALARM
    drive(1, 0, 8'h00, 0); exp_next("t6_arm", S_ARM, 8'h00, 0, 0, 0); tick();
    drive(0, 0, 8'h10, 0); exp_next("t6_latch", S_ENT, 8'h10, 4, 1, 0); tick();
    drive(0, 0, 8'h00, 0);
    for (int i = 1; i < DELAY; i++) begin
      exp_next($sformatf("t6_entry%0d", i), S_ENT, 8'h10, 4, 1, 0); tick();
    end
    exp_next("t6_alarm", S_ALM, 8'h10, 4, 1, 1); tick();
    @(negedge clk); #1;
    exp_at(-1, "t6_async_rst", S_DIS, 8'h00, 0, 0, 0);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    drive(0, 0, 8'h02, 0); exp_next("t6_noarm0", S_DIS, 8'h00, 0, 0, 0); tick();
    exp_next("t6_noarm1", S_DIS, 8'h00, 0, 0, 0); tick();
    drive(1, 0, 8'h00, 0); exp_next("t6_rearm", S_ARM, 8'h00, 0, 0, 0); tick();
    drive(0, 0, 8'h02, 0); exp_next("t6_relatch", S_ENT, 8'h02, 1, 1, 0); tick();
    drive(0, 0, 8'h00, 0);
    tick(); tick();
    @(negedge clk); #1;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations never checked, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_zone_controller.md
ALARM_ZONE_CONTROLLER -- requirements
Module: alarm_zone_controller

Interface
REQ-001 The block SHALL have parameter NZ, default 8, giving the number of zones; legal range 2..32.
REQ-002 The block SHALL have parameter DELAY, default 16, giving the entry-delay length in clock cycles; legal range 1..255.
REQ-003 The block SHALL derive localparam ZW = $clog2(NZ) for the zone-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port arm, input, 1 bit: request to arm.
REQ-007 The block SHALL have port disarm, input, 1 bit: request to disarm; has priority over every other input.
REQ-008 The block SHALL have port zone, input, NZ bits: sensor inputs; bit 0 is the highest priority.
REQ-009 The block SHALL have port ack, input, 1 bit: operator acknowledge of the reported zone.
REQ-010 The block SHALL have port intruder_zone, output, ZW bits: index of the highest-priority latched zone.
REQ-011 The block SHALL have port valid, output, 1 bit: asserted when any zone is latched.
REQ-012 The block SHALL have port buzzer, output, 1 bit: asserted in state ALARM.
REQ-013 The block SHALL have port pending, output, NZ bits: the latched-zone register.
REQ-014 The block SHALL have port state, output, 2 bits: the current FSM state code.

Function
REQ-015 FSM states SHALL be DISARMED=0, ARMED=1, ENTRY=2, ALARM=3.
REQ-016 In DISARMED, pending SHALL hold all zeros, zone SHALL be ignored, and arm=1 SHALL move the FSM to ARMED on the next edge.
REQ-017 In ARMED, ENTRY and ALARM, pending[i] SHALL be set on the edge after zone[i]=1 is sampled; bits are sticky until cleared.
REQ-018 ARMED SHALL move to ENTRY on the same edge at which any zone bit is first latched.
REQ-019 ENTRY SHALL run a delay counter, cleared on entry and incremented each cycle, and move to ALARM on the edge at which the counter equals DELAY-1, so buzzer rises exactly DELAY cycles after the ENTRY state begins.
REQ-020 In ALARM, ack=1 with valid=1 SHALL clear pending[intruder_zone] on the next edge.
REQ-021 In ALARM, ack=1 with valid=1 SHALL return the FSM to ARMED on that edge when the ack empties pending and no zone bit is sampled in the same cycle.
REQ-022 ack SHALL be ignored outside ALARM and whenever valid=0.
REQ-023 If ack clears bit i while zone[i]=1 in the same cycle, the set SHALL win and pending[i] SHALL remain 1.
REQ-024 disarm=1 in any state SHALL move the FSM to DISARMED and clear pending and the counter on the next edge; with arm=1 in the same cycle, disarm SHALL win.
REQ-025 arm=1 in any state other than DISARMED SHALL have no effect.
REQ-026 intruder_zone SHALL be combinational from pending: it gives the lowest set index, and is 0 when pending=0.
REQ-027 valid SHALL equal the OR of all pending bits, and buzzer SHALL equal (state==ALARM); neither has added latency.
REQ-028 The counter width SHALL be $clog2(DELAY+1); the counter SHALL never wrap, and SHALL hold at zero outside ENTRY.

Reset
REQ-029 reset=1 SHALL force state=DISARMED, pending=0 and counter=0 immediately, regardless of clk.
REQ-030 During reset, intruder_zone, valid and buzzer SHALL all read 0.
REQ-031 Reset asserted mid-ENTRY or mid-ALARM SHALL abandon the sequence, and after release the block SHALL need a new arm.

Structure
REQ-032 A shared package alarm_pkg SHALL hold the state-code constants and the default NZ/DELAY values.
REQ-033 The priority encoder (pending -> intruder_zone, valid) SHALL be a separate parametrised sub-module, alarm_priority_enc #(NZ), instantiated once.

Verification
REQ-034 Test 1: NZ=8, DELAY=4, arm, then zone=8'h20 for 1 cycle -> pending=8'h20 next cycle, state=ENTRY, buzzer=1 exactly 4 cycles later, intruder_zone=5, valid=1.
REQ-035 Test 2: in ALARM with pending=8'h24, ack -> pending=8'h20 and intruder_zone=5; ack again -> pending=0, valid=0, state=ARMED, buzzer=0.
REQ-036 Test 3: in ENTRY at counter=2, disarm -> DISARMED next edge, pending=0, and buzzer never asserts.
REQ-037 Test 4: in ALARM with pending=8'h01, ack together with zone=8'h01 -> pending stays 8'h01 and the state stays ALARM.
REQ-038 Test 5: arm and disarm together from DISARMED -> the state stays DISARMED; then zone=8'hFF while DISARMED -> pending stays 0.
REQ-039 Test 6: reset pulse between clock edges while in ALARM -> the outputs clear immediately; after release, zone input alone changes nothing until arm.
